// File: rtl/bkg_blitter.sv
// Background frame-buffer write engine: copies a ROM sprite into the 320x240
// background RAM (skipping transparent pixels) or fills a rectangle with one index.
module bkg_blitter #(
    parameter int unsigned SCREEN_W        = 320,
    parameter int unsigned SCREEN_H        = 240,
    parameter int unsigned FB_ADDR_W       = 17,
    parameter int unsigned SRC_ADDR_W      = 16,
    parameter logic [4:0]  TRANSPARENT_IDX = 5'h0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [4:0]            fill_index,
    input  logic [8:0]            dst_x,
    input  logic [8:0]            dst_y,
    input  logic [8:0]            width,
    input  logic [8:0]            height,
    input  logic [SRC_ADDR_W-1:0] src_base,
    output logic [SRC_ADDR_W-1:0] src_address,
    input  logic [4:0]            src_data,
    output logic [FB_ADDR_W-1:0]  write_address,
    output logic [4:0]            data_In,
    output logic                  we,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = 9;
    localparam int unsigned PW = 10;
    localparam int unsigned IW = 5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   req_x, req_y, req_w, req_h;
    logic            req_fill;
    logic [IW-1:0]   req_idx;
    logic [CW-1:0]   col, row;
    logic            tail;

    // Stage aligned with src_data: the pixel whose ROM read is returning now.
    logic            s2_valid, s2_inb, s2_fill;
    logic [IW-1:0]   s2_idx;

    logic [PW-1:0]        px, py;
    logic [FB_ADDR_W-1:0] py_ext, pix_addr;
    logic                 last_col, last_row, in_bounds;

    // Address of the pixel currently being presented to the ROM.
    always_comb begin
        px        = PW'(req_x) + PW'(col);
        py        = PW'(req_y) + PW'(row);
        py_ext    = FB_ADDR_W'(py);
        pix_addr  = (py_ext << 8) + (py_ext << 6) + FB_ADDR_W'(px);
        in_bounds = (px < PW'(SCREEN_W)) && (py < PW'(SCREEN_H));
        last_col  = (col == req_w - CW'(1));
        last_row  = (row == req_h - CW'(1));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            req_x         <= '0;
            req_y         <= '0;
            req_w         <= '0;
            req_h         <= '0;
            req_fill      <= 1'b0;
            req_idx       <= '0;
            col           <= '0;
            row           <= '0;
            tail          <= 1'b0;
            s2_valid      <= 1'b0;
            s2_inb        <= 1'b0;
            s2_fill       <= 1'b0;
            s2_idx        <= '0;
            src_address   <= '0;
            write_address <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            s2_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req_x    <= dst_x;
                        req_y    <= dst_y;
                        req_w    <= width;
                        req_h    <= height;
                        req_fill <= fill_mode;
                        req_idx  <= fill_index;
                        col      <= '0;
                        row      <= '0;
                        tail     <= 1'b0;
                        if (width == '0 || height == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            src_address <= src_base;
                        end
                    end
                end
                RUN: begin
                    if (!tail) begin
                        s2_valid      <= 1'b1;
                        s2_inb        <= in_bounds;
                        s2_fill       <= req_fill;
                        s2_idx        <= req_idx;
                        write_address <= pix_addr;
                        if (last_col) begin
                            col <= '0;
                            if (last_row) tail <= 1'b1;
                            else          row  <= row + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (!(last_col && last_row))
                            src_address <= src_address + SRC_ADDR_W'(1);
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ROM data arrives in the write cycle, so the final gate is combinational on it.
    assign we      = s2_valid && s2_inb && (s2_fill || (src_data != TRANSPARENT_IDX));
    assign data_In = s2_fill ? s2_idx : src_data;

endmodule

// File: tb/tb_bkg_blitter.sv
// Directed bench for bkg_blitter: fill, copy with transparency, clipping,
// zero size, held start and mid-operation reset, with a synchronous ROM model.
module tb_bkg_blitter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        fill_mode = 1'b0;
    logic [4:0]  fill_index = '0;
    logic [8:0]  dst_x = '0, dst_y = '0, width = '0, height = '0;
    logic [15:0] src_base = '0;
    logic [15:0] src_address;
    logic [4:0]  src_data = '0;
    logic [16:0] write_address;
    logic [4:0]  data_In;
    logic        we, busy, done;

    bkg_blitter dut (
        .Clk(Clk), .Reset(Reset), .start(start), .fill_mode(fill_mode),
        .fill_index(fill_index), .dst_x(dst_x), .dst_y(dst_y), .width(width),
        .height(height), .src_base(src_base), .src_address(src_address),
        .src_data(src_data), .write_address(write_address), .data_In(data_In),
        .we(we), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    logic [4:0] rom [65536];
    always @(posedge Clk) src_data <= rom[src_address];

    int checks = 0;
    int errors = 0;
    int nwr, ndn, nbusy, bfirst;
    int wa[64], wd[64], wc[64], dc[4], sa[8];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Issue one request in cycle 0 and log outputs for cycles 1..maxc.
    task automatic run_op(input logic fm, input logic [4:0] fi,
                          input logic [8:0] x, input logic [8:0] y,
                          input logic [8:0] w, input logic [8:0] h,
                          input logic [15:0] base, input bit hold,
                          input int rst_cyc, input int ndone, input int maxc);
        nwr = 0; ndn = 0; nbusy = 0; bfirst = -1;
        @(negedge Clk);
        fill_mode = fm; fill_index = fi; dst_x = x; dst_y = y;
        width = w; height = h; src_base = base; start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge Clk);
            if (c < 8) sa[c] = int'(src_address);
            if (we && nwr < 64) begin
                wa[nwr] = int'(write_address); wd[nwr] = int'(data_In); wc[nwr] = c;
                nwr++;
            end
            if (busy) begin
                if (bfirst < 0) bfirst = c;
                nbusy++;
            end
            if (done && ndn < 4) begin
                dc[ndn] = c;
                ndn++;
            end
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                check("rst_we", int'(we), 0);
                check("rst_busy", int'(busy), 0);
            end
            Reset = (c == rst_cyc);
            if (!hold) begin
                start = 1'b0;
                fill_mode = ~fm; fill_index = ~fi; dst_x = 9'h1ff; dst_y = 9'h1ff;
                width = 9'd7; height = 9'd7; src_base = 16'hffff;
            end
            if (ndone > 0 && ndn >= ndone) break;
        end
        start = 1'b0;
        Reset = 1'b0;
        if (ndn < ndone) check("timeout_done", ndn, ndone);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 5'd0;
        rom[100] = 5'd3; rom[101] = 5'd0; rom[102] = 5'd5;

        repeat (3) @(negedge Clk);
        check("rst_we0", int'(we), 0);
        check("rst_busy0", int'(busy), 0);
        check("rst_done0", int'(done), 0);
        check("rst_src0", int'(src_address), 0);
        check("rst_wa0", int'(write_address), 0);
        Reset = 1'b0;

        // Fill 4x2 at (10,20), index 7
        run_op(1'b1, 5'd7, 9'd10, 9'd20, 9'd4, 9'd2, 16'd0, 1'b0, -1, 1, 100);
        check("fill_nwr", nwr, 8);
        for (int i = 0; i < 8; i++) begin
            check("fill_addr", wa[i], (i < 4) ? 6410 + i : 6730 + i - 4);
            check("fill_data", wd[i], 7);
            check("fill_cyc", wc[i], 2 + i);
        end
        check("fill_done", dc[0], 11);
        check("fill_bfirst", bfirst, 1);
        check("fill_nbusy", nbusy, 10);

        // Copy 3x1 from ROM 100 with a transparent middle pixel
        run_op(1'b0, 5'd9, 9'd0, 9'd0, 9'd3, 9'd1, 16'd100, 1'b0, -1, 1, 100);
        check("copy_sa1", sa[1], 100);
        check("copy_sa2", sa[2], 101);
        check("copy_sa3", sa[3], 102);
        check("copy_nwr", nwr, 2);
        check("copy_a0", wa[0], 0);
        check("copy_d0", wd[0], 3);
        check("copy_c0", wc[0], 2);
        check("copy_a1", wa[1], 2);
        check("copy_d1", wd[1], 5);
        check("copy_c1", wc[1], 4);
        check("copy_done", dc[0], 6);

        // Right/bottom clipping
        run_op(1'b1, 5'd1, 9'd318, 9'd238, 9'd4, 9'd4, 16'd0, 1'b0, -1, 1, 100);
        check("clip_nwr", nwr, 4);
        check("clip_a0", wa[0], 76478);
        check("clip_a1", wa[1], 76479);
        check("clip_a2", wa[2], 76798);
        check("clip_a3", wa[3], 76799);
        check("clip_c2", wc[2], 6);
        check("clip_d3", wd[3], 1);
        check("clip_done", dc[0], 19);

        // Held start: exactly one op, the next accepted right after done
        run_op(1'b1, 5'd4, 9'd0, 9'd0, 9'd2, 9'd2, 16'd0, 1'b1, -1, 2, 100);
        check("hold_done0", dc[0], 7);
        check("hold_done1", dc[1], 15);
        check("hold_nwr", nwr, 8);
        check("hold_nbusy", nbusy, 12);

        // Reset during cycle 3 of a 10x10 fill
        run_op(1'b1, 5'd9, 9'd0, 9'd0, 9'd10, 9'd10, 16'd0, 1'b0, 3, 0, 20);
        check("rst_ndone", ndn, 0);
        check("rst_nwr", nwr, 2);
        check("rst_nbusy", nbusy, 3);

        // Zero size after reset: src_address must stay at its reset value
        run_op(1'b1, 5'd2, 9'd5, 9'd5, 9'd0, 9'd5, 16'd500, 1'b0, -1, 1, 20);
        check("zero_done", dc[0], 1);
        check("zero_nwr", nwr, 0);
        check("zero_nbusy", nbusy, 0);
        check("zero_sa1", sa[1], 0);

        // Normal op after reset: corner pixel with fill index 0, second column clipped
        run_op(1'b1, 5'd0, 9'd319, 9'd239, 9'd2, 9'd1, 16'd0, 1'b0, -1, 1, 100);
        check("post_nwr", nwr, 1);
        check("post_a0", wa[0], 76799);
        check("post_d0", wd[0], 0);
        check("post_done", dc[0], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
